rr_burst_arbiter: RTL

- Round-robin arbiter that shares one downstream channel among NUM requesters. Each requester sends multi-beat bursts.
- Once a requester wins, the grant stays with it until the beat flagged last is accepted. Priority then rotates to the requester after the winner.
- Zero-latency pass-through: no data buffering. Sequential state is the priority pointer and the burst lock only.
- Sits in front of shared ports such as the memory request path or writeback buses.

---
 rtl/rr_burst_arbiter_pkg.sv | 15 +
 rtl/rr_burst_arbiter_pick.sv | 50 +++++
 rtl/rr_burst_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared arbitration types and helpers for the round-robin burst arbiter
// and other round-robin schedulers.
package rr_burst_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    // Explicit modulo so a non-power-of-two requester count still wraps to 0.
    function automatic int unsigned next_ptr(input int unsigned id, input int unsigned num);
        return (id + 1 >= num) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Round-robin pick: the lowest valid index at or above ptr, else the lowest
// valid index overall.
module rr_pick
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM      = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM)
) (
    input  logic [NUM-1:0]      req_valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any_valid
);

    logic [NUM-1:0] mask;
    logic [NUM-1:0] hi;
    logic           hi_found;
    logic           lo_found;
    logic [ID_WIDTH-1:0] hi_id;
    logic [ID_WIDTH-1:0] lo_id;

    // Thermometer mask keeps requesters at or above the pointer.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            mask[i] = (ID_WIDTH'(i) >= ptr);
        end
        hi = req_valid & mask;
    end

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (!hi_found && hi[i]) begin
                hi_found = 1'b1;
                hi_id    = ID_WIDTH'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_WIDTH'(i);
            end
        end
        grant_id  = hi_found ? hi_id : lo_id;
        any_valid = lo_found;
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: zero-latency pass-through of NUM requesters onto
// one channel, holding the grant until the winning burst's last beat.
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM        = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = $clog2(NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM-1:0]                 req_valid,
    input  logic [NUM-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [NUM-1:0]                 req_last,
    output logic [NUM-1:0]                 req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [ID_WIDTH-1:0]            out_id,
    input  logic                           out_ready
);

    arb_state_t          state;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] lock_id;
    logic [ID_WIDTH-1:0] pick_id;
    logic                any_valid;
    logic [ID_WIDTH-1:0] grant;
    logic                beat_valid;
    logic                fire;

    rr_pick #(
        .NUM      (NUM),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant_id  (pick_id),
        .any_valid (any_valid)
    );

    // A locked requester that drops valid leaves a bubble; no re-arbitration.
    always_comb begin
        grant      = (state == ARB_LOCK) ? lock_id : pick_id;
        beat_valid = (state == ARB_LOCK) ? req_valid[lock_id] : any_valid;
        fire       = beat_valid & out_ready;

        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_id    = '0;
        req_ready = '0;
        if (rst) begin
            out_valid = beat_valid;
            out_data  = req_data[grant];
            out_last  = req_last[grant];
            out_id    = grant;
            if (fire) begin
                req_ready[grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            lock_id <= '0;
        end else if (flush) begin
            state <= ARB_IDLE;
        end else if (fire) begin
            if (req_last[grant]) begin
                state <= ARB_IDLE;
                ptr   <= ID_WIDTH'(next_ptr(32'(grant), NUM));
            end else begin
                state   <= ARB_LOCK;
                lock_id <= grant;
            end
        end
    end

endmodule
